// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: shares one 8-to-16-bit immediate extension datapath
// between decode (port 0) and the branch-target unit (port 1).
// Round-robin arbitration feeds a single registered result slot.
//
// Optional feature macro: IMM_LUI_EN
//   defined   -> mode 2'b10 produces the upper immediate {imm, 8'h00}
//   undefined -> mode 2'b10 falls back to sign-extension
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | result slot free, resp_valid low
// ST_FULL  | result slot holds a result, resp_valid high
module imm_ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_imm,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_data,
  input  logic        resp_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state;
  logic        last_grant;
  logic        can_accept;
  logic        grant_valid;
  logic        grant_id;
  logic [7:0]  sel_imm;
  logic [1:0]  sel_mode;
  logic [15:0] ext_data;

  function automatic logic [15:0] ext(input logic [7:0] imm, input logic [1:0] mode);
    logic [15:0] r;
    case (mode)
      2'b01:   r = {8'h00, imm};
`ifdef IMM_LUI_EN
      2'b10:   r = {imm, 8'h00};
`endif
      2'b11:   r = {{7{imm[7]}}, imm, 1'b0};
      default: r = {{8{imm[7]}}, imm};
    endcase
    return r;
  endfunction

  // A new grant is allowed when the slot is free or is being drained this cycle.
  assign can_accept = (state == ST_EMPTY) || resp_ready;

  // Round-robin grant: on a tie the port that did not win last time goes.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && (grant_id == 1'b0);
  assign req1_ready = grant_valid && (grant_id == 1'b1);

  assign sel_imm  = grant_id ? req1_imm  : req0_imm;
  assign sel_mode = grant_id ? req1_mode : req0_mode;
  assign ext_data = ext(sel_imm, sel_mode);

  // Result slot: load on grant, drain when consumed, held under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_data  <= 16'h0000;
    end else if (grant_valid) begin
      state      <= ST_FULL;
      last_grant <= grant_id;
      resp_id    <= grant_id;
      resp_data  <= ext_data;
    end else if ((state == ST_FULL) && resp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign resp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: a sequential vector table plus
// hand-written sequences for reset and asynchronous reset while FULL.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_imm, req1_imm;
  logic [1:0]  req0_mode, req1_mode;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_ready;
  logic [15:0] resp_data;

  int tests = 0;
  int fails = 0;

`ifdef IMM_LUI_EN
  localparam logic [15:0] EXP_M10 = 16'hF000;
`else
  localparam logic [15:0] EXP_M10 = 16'hFFF0;
`endif

  typedef struct {
    logic        v0;
    logic [7:0]  imm0;
    logic [1:0]  mode0;
    logic        v1;
    logic [7:0]  imm1;
    logic [1:0]  mode1;
    logic        rr;
    logic        exp_rdy0;
    logic        exp_rdy1;
    logic        exp_valid;
    logic        exp_id;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vq[$];

  imm_ext_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_mode(req1_mode), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_imm = v.imm0; req0_mode = v.mode0;
    req1_valid = v.v1; req1_imm = v.imm1; req1_mode = v.mode1;
    resp_ready = v.rr;
  endtask

  initial begin
    vec_t idle;
    vec_t both;
    idle = '{1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    // reset-state, first grant, modes on port 1
    vq.push_back('{1'b1, 8'h85, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFF85});
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b1, 8'hF0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00F0});
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b1, 8'hF0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFE0});
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b1, 8'hF0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, EXP_M10});
    // continuous contention: grants alternate 0,1,0,1 with no gaps
    vq.push_back('{1'b1, 8'h7F, 2'b11, 1'b1, 8'h80, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00FE});
    vq.push_back('{1'b1, 8'h7F, 2'b11, 1'b1, 8'h80, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0080});
    vq.push_back('{1'b1, 8'h7F, 2'b11, 1'b1, 8'h80, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00FE});
    vq.push_back('{1'b1, 8'h7F, 2'b11, 1'b1, 8'h80, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0080});
    // drain with no requests, then idle EMPTY holds id/data
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080});
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080});
    // EMPTY accepts without resp_ready
    vq.push_back('{1'b1, 8'h80, 2'b01, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080});
    // backpressure five cycles, then same-edge grant to port 1
    for (int i = 0; i < 5; i++)
      vq.push_back('{1'b0, 8'h00, 2'b00, 1'b1, 8'h12, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080});
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b1, 8'h12, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0012});
    // FULL, no requests, held
    vq.push_back('{1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0012});

    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {15'b0, resp_valid}, 16'h0000);
    check("reset_id", {15'b0, resp_id}, 16'h0000);
    check("reset_data", resp_data, 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rdy0", {15'b0, req0_ready}, 16'h0000);
    check("idle_rdy1", {15'b0, req1_ready}, 16'h0000);

    foreach (vq[i]) begin
      drive(vq[i]);
      #1;
      check($sformatf("v%0d_rdy0", i), {15'b0, req0_ready}, {15'b0, vq[i].exp_rdy0});
      check($sformatf("v%0d_rdy1", i), {15'b0, req1_ready}, {15'b0, vq[i].exp_rdy1});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {15'b0, resp_valid}, {15'b0, vq[i].exp_valid});
      check($sformatf("v%0d_id", i), {15'b0, resp_id}, {15'b0, vq[i].exp_id});
      check($sformatf("v%0d_data", i), resp_data, vq[i].exp_data);
    end

    // async reset between edges while FULL; no clock edge in this window
    drive(idle);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", {15'b0, resp_valid}, 16'h0000);
    check("areset_id", {15'b0, resp_id}, 16'h0000);
    check("areset_data", resp_data, 16'h0000);
    #1 reset = 1'b0;

    // after release a tie goes to port 0
    both = '{1'b1, 8'h01, 2'b00, 1'b1, 8'h02, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    drive(both);
    #1;
    check("tie_rdy0", {15'b0, req0_ready}, 16'h0001);
    check("tie_rdy1", {15'b0, req1_ready}, 16'h0000);
    @(posedge clk);
    #1;
    check("tie_valid", {15'b0, resp_valid}, 16'h0001);
    check("tie_id", {15'b0, resp_id}, 16'h0000);
    check("tie_data", resp_data, 16'h0001);
    #1;
    check("tie2_rdy1", {15'b0, req1_ready}, 16'h0001);
    @(posedge clk);
    #1;
    check("tie2_id", {15'b0, resp_id}, 16'h0001);
    check("tie2_data", resp_data, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
